// File: rtl/dff_strobe_driver.sv
// Sequences D/T/_PC/_PS toward an emulated 74-style edge-triggered flip-flop with
// programmable setup, pulse and recovery times. Optional Q readback check: DFF_STROBE_READBACK_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for REQ; also retires BUSY/DONE after a completion
// SETUP   | D driven, T low, SETUP_CYC cycles before the clock edge
// ACTIVE  | T high, or _PS/_PC low, for HIGH_CYC cycles
// RECOVER | all controls inactive, D held, LOW_CYC cycles
// FINISH  | one cycle before the DONE pulse; readback compare happens here

module dff_strobe_driver #(
    parameter int unsigned SETUP_CYC = 20,
    parameter int unsigned HIGH_CYC  = 440,
    parameter int unsigned LOW_CYC   = 40,
    parameter int unsigned CW        = 10
) (
    input  logic       U,
    input  logic       RESET,
    input  logic       REQ,
    input  logic [1:0] OP,
    input  logic       DIN,
    output logic       D,
    output logic       T,
    output logic       _PC,
    output logic       _PS,
    input  logic       Q,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int unsigned MAX_CYC =
        (SETUP_CYC > HIGH_CYC) ? ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC)
                               : ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);

    if (SETUP_CYC < 1 || HIGH_CYC < 1 || LOW_CYC < 1) begin : g_bad_cyc
        $error("dff_strobe_driver: SETUP_CYC, HIGH_CYC and LOW_CYC must all be >= 1");
    end
    if ((MAX_CYC >> CW) != 0) begin : g_bad_cw
        $error("dff_strobe_driver: CW too narrow for the largest *_CYC value");
    end

    localparam logic [1:0] OP_CLK = 2'b00;
    localparam logic [1:0] OP_PRE = 2'b01;
    localparam logic [1:0] OP_RES = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_RECOVER,
        S_FINISH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

`ifdef DFF_STROBE_READBACK_EN
    logic [1:0] op_q;
    logic       exp_q;

    // Reserved opcode never touches the flip-flop, so it is never compared.
    assign exp_q = (op_q == OP_CLK) ? D : (op_q == OP_PRE);
`else
    logic unused_q;

    assign unused_q = Q;
    assign ERR      = 1'b0;
`endif

    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
            D     <= 1'b0;
            T     <= 1'b0;
            _PC   <= 1'b1;
            _PS   <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
`ifdef DFF_STROBE_READBACK_EN
            op_q  <= 2'b00;
            ERR   <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    BUSY <= 1'b0;
                    // BUSY still high here means DONE is showing; no acceptance that cycle.
                    if (REQ && !BUSY) begin
`ifdef DFF_STROBE_READBACK_EN
                        op_q <= OP;
`endif
                        if (OP == OP_RES) begin
                            state <= S_FINISH;
                        end else begin
                            BUSY <= 1'b1;
`ifdef DFF_STROBE_READBACK_EN
                            ERR  <= 1'b0;
`endif
                            if (OP == OP_CLK) begin
                                D     <= DIN;
                                cnt   <= CW'(SETUP_CYC - 1);
                                state <= S_SETUP;
                            end else begin
                                cnt   <= CW'(HIGH_CYC - 1);
                                state <= S_ACTIVE;
                                if (OP == OP_PRE) begin
                                    _PS <= 1'b0;
                                end else begin
                                    _PC <= 1'b0;
                                end
                            end
                        end
                    end
                end

                S_SETUP: begin
                    if (cnt_zero) begin
                        T     <= 1'b1;
                        cnt   <= CW'(HIGH_CYC - 1);
                        state <= S_ACTIVE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_ACTIVE: begin
                    if (cnt_zero) begin
                        T     <= 1'b0;
                        _PC   <= 1'b1;
                        _PS   <= 1'b1;
                        cnt   <= CW'(LOW_CYC - 1);
                        state <= S_RECOVER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_RECOVER: begin
                    if (cnt_zero) begin
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_FINISH: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b1;
                    state <= S_IDLE;
`ifdef DFF_STROBE_READBACK_EN
                    if (op_q != OP_RES && Q != exp_q) begin
                        ERR <= 1'b1;
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_strobe_driver.sv
// Scoreboard bench for dff_strobe_driver: stimulus pushes expected completions,
// a negedge monitor pops and checks them on every DONE pulse.

module tb_dff_strobe_driver;

    logic       U = 1'b0;
    logic       RESET;
    logic       REQ;
    logic [1:0] OP;
    logic       DIN;
    logic       Q;
    logic       D, T, pc_n, ps_n, BUSY, DONE, ERR;

    logic q_model  = 1'b0;
    logic q_force  = 1'b0;
    logic q_forced = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    localparam int LAT_CLK = 501;
    localparam int LAT_PCS = 481;
    localparam int T_RISE  = 20;
    localparam int W_HIGH  = 440;

`ifdef DFF_STROBE_READBACK_EN
    localparam logic ERR_ON_BAD_Q = 1'b1;
`else
    localparam logic ERR_ON_BAD_Q = 1'b0;
`endif

    dff_strobe_driver dut (
        .U    (U),
        .RESET(RESET),
        .REQ  (REQ),
        .OP   (OP),
        .DIN  (DIN),
        .D    (D),
        .T    (T),
        ._PC  (pc_n),
        ._PS  (ps_n),
        .Q    (Q),
        .BUSY (BUSY),
        .DONE (DONE),
        .ERR  (ERR)
    );

    always #5 U = ~U;

    always @(posedge U) cyc++;

    // Behavioural 74-style flip-flop with async clear/preset.
    always @(posedge T or negedge pc_n or negedge ps_n) begin
        if (!pc_n)      q_model <= 1'b0;
        else if (!ps_n) q_model <= 1'b1;
        else            q_model <= D;
    end

    assign Q = q_force ? q_forced : q_model;

    typedef struct {
        string name;
        int    done_cyc;
        int    t_rise;
        logic  d;
        int    t_hi;
        int    ps_lo;
        int    pc_lo;
        logic  q;
        logic  err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    int   m_t_hi = 0, m_ps_lo = 0, m_pc_lo = 0, m_t_rise = -1;
    bit   after_done = 0;
    logic prev_t = 1'b0, prev_d = 1'b0;

    always @(negedge U) begin
        exp_t e;
        if (RESET) begin
            m_t_hi = 0; m_ps_lo = 0; m_pc_lo = 0; m_t_rise = -1;
            after_done = 0;
        end else begin
            if (after_done) begin
                chk("busy_after_done", BUSY, 0);
                chk("done_width", DONE, 0);
                after_done = 0;
            end
            if (T) begin
                if (m_t_rise < 0) m_t_rise = cyc;
                m_t_hi++;
            end
            if (!ps_n) m_ps_lo++;
            if (!pc_n) m_pc_lo++;
            if (int'(T) + int'(!ps_n) + int'(!pc_n) > 1) begin
                miscompares++;
                $display("FAIL exclusive_controls: T=%0b _PS=%0b _PC=%0b (cycle %0d)",
                         T, ps_n, pc_n, cyc);
            end
            if (T && prev_t && D !== prev_d) begin
                miscompares++;
                $display("FAIL d_stable_while_t: D went %0b -> %0b (cycle %0d)", prev_d, D, cyc);
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got DONE=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_done_cyc"}, cyc, e.done_cyc);
                    chk({e.name, "_t_rise"}, m_t_rise, e.t_rise);
                    chk({e.name, "_t_high"}, m_t_hi, e.t_hi);
                    chk({e.name, "_ps_low"}, m_ps_lo, e.ps_lo);
                    chk({e.name, "_pc_low"}, m_pc_lo, e.pc_lo);
                    chk({e.name, "_d"}, D, e.d);
                    chk({e.name, "_q"}, Q, e.q);
                    chk({e.name, "_err"}, ERR, e.err);
                    chk({e.name, "_busy_at_done"}, BUSY, 1);
                end
                m_t_hi = 0; m_ps_lo = 0; m_pc_lo = 0; m_t_rise = -1;
                after_done = 1;
            end
        end
        prev_t = T;
        prev_d = D;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge U);
        while ((BUSY || DONE) && n < 3000) begin
            @(negedge U);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: BUSY=%0b after %0d cycles, expected 0", BUSY, n);
        end
    endtask

    // lat < 0: command is expected to be aborted, nothing is pushed.
    task automatic send(input logic [1:0] op, input logic din, input string name,
                        input int lat, input int trise_off, input logic exp_d,
                        input int thi, input int psl, input int pcl,
                        input logic expq, input logic experr);
        exp_t e;
        int   a;
        wait_idle();
        REQ = 1'b1; OP = op; DIN = din;
        @(posedge U);
        #1;
        a = cyc;
        if (lat >= 0) begin
            e.name     = name;
            e.done_cyc = a + lat;
            e.t_rise   = (trise_off < 0) ? -1 : a + trise_off;
            e.d        = exp_d;
            e.t_hi     = thi;
            e.ps_lo    = psl;
            e.pc_lo    = pcl;
            e.q        = expq;
            e.err      = experr;
            sb.push_back(e);
        end
        @(negedge U);
        REQ = 1'b0;
        if (op == 2'b11) begin
            chk({name, "_no_busy_at_accept"}, BUSY, 0);
        end else begin
            chk({name, "_busy_at_accept"}, BUSY, 1);
            chk({name, "_err_cleared"}, ERR, 0);
            if (op == 2'b00) chk({name, "_d_at_accept"}, D, din);
        end
    endtask

    initial begin
        RESET = 1'b1; REQ = 1'b0; OP = 2'b00; DIN = 1'b0;
        repeat (3) @(negedge U);
        chk("rst_d", D, 0);
        chk("rst_t", T, 0);
        chk("rst_pc", pc_n, 1);
        chk("rst_ps", ps_n, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        RESET = 1'b0;

        send(2'b00, 1'b1, "clk1",   LAT_CLK, T_RISE, 1'b1, W_HIGH, 0, 0, 1'b1, 1'b0);
        send(2'b01, 1'b0, "preset", LAT_PCS, -1,     1'b1, 0, W_HIGH, 0, 1'b1, 1'b0);
        send(2'b10, 1'b0, "clear",  LAT_PCS, -1,     1'b1, 0, 0, W_HIGH, 1'b0, 1'b0);

        // REQ with DIN=0 in the middle of the pulse must be dropped.
        send(2'b00, 1'b1, "clk_ign", LAT_CLK, T_RISE, 1'b1, W_HIGH, 0, 0, 1'b1, 1'b0);
        repeat (100) @(negedge U);
        REQ = 1'b1; OP = 2'b00; DIN = 1'b0;
        @(negedge U);
        REQ = 1'b0;

        // Async reset 100 cycles into the active phase.
        send(2'b00, 1'b1, "clk_rst", -1, 0, 1'b1, 0, 0, 0, 1'b1, 1'b0);
        repeat (T_RISE + 100) @(negedge U);
        chk("pre_rst_t", T, 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_t", T, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_pc", pc_n, 1);
        chk("async_rst_ps", ps_n, 1);
        chk("async_rst_d", D, 0);
        repeat (3) @(negedge U);
        RESET = 1'b0;

        send(2'b00, 1'b0, "clk_post_rst", LAT_CLK, T_RISE, 1'b0, W_HIGH, 0, 0, 1'b0, 1'b0);
        send(2'b11, 1'b1, "op11",         1,       -1,     1'b0, 0, 0, 0, 1'b0, 1'b0);

        q_forced = 1'b0;
        q_force  = 1'b1;
        send(2'b00, 1'b1, "rb_bad", LAT_CLK, T_RISE, 1'b1, W_HIGH, 0, 0, 1'b0, ERR_ON_BAD_Q);
        wait_idle();
        chk("rb_err_sticky", ERR, ERR_ON_BAD_Q);
        q_force = 1'b0;
        send(2'b00, 1'b1, "rb_ok", LAT_CLK, T_RISE, 1'b1, W_HIGH, 0, 0, 1'b1, 1'b0);

        wait_idle();
        repeat (3) @(negedge U);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
